// File: rtl/data_path.sv
// ---------------------------------------------------------------------------
// data_path -- 32-bit single-bus processor datapath.
//
// General registers R1-R3, PC, IR, MAR, MDR, Y and Z share one bus. Each
// register has an out-enable that drives the bus and an in-enable that loads
// it on the rising clock edge. The ALU is combinational: operand A is Y,
// operand B is the bus, the operation is IR[31:27], and IncPC forces bus+1.
//
// Optional feature macro: DATAPATH_MUL_EN
//   defined   : Z is 64 bits, opcode 8 is the unsigned 64-bit product, and
//               the extra input Zhighout drives Z[63:32] onto the bus
//   undefined : Z is 32 bits, opcode 8 yields 0, no Zhighout port
//
// Ports:
//   clock              rising-edge clock for all registers
//   clear              synchronous active-low reset of all registers
//   R1in..R3in         load general register from the bus
//   R1out..R3out       drive general register onto the bus
//   MDRin / MDRout     load / drive MDR
//   MD_read            MDR input select: 1 = Mdatain, 0 = bus
//   MARin, PCin, IRin  load MAR / PC / IR from the bus
//   PCout              drive PC onto the bus
//   Yin                load Y from the bus
//   Zlowin             load Z from the ALU result
//   Zlowout            drive Z[31:0] onto the bus
//   Zhighout           drive Z[63:32] onto the bus (DATAPATH_MUL_EN only)
//   IncPC              ALU result = bus + 1, overriding the opcode
//   Mdatain            memory read data
//   BusMuxOut          current bus value
//   MAR_q, IR_q, PC_q, R1_q  register observation outputs
// ---------------------------------------------------------------------------
module data_path #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             R1in,
    input  logic             R2in,
    input  logic             R3in,
    input  logic             R1out,
    input  logic             R2out,
    input  logic             R3out,
    input  logic             MDRin,
    input  logic             MDRout,
    input  logic             MD_read,
    input  logic             MARin,
    input  logic             PCin,
    input  logic             PCout,
    input  logic             IRin,
    input  logic             Yin,
    input  logic             Zlowin,
    input  logic             Zlowout,
`ifdef DATAPATH_MUL_EN
    input  logic             Zhighout,
`endif
    input  logic             IncPC,
    input  logic [WIDTH-1:0] Mdatain,
    output logic [WIDTH-1:0] BusMuxOut,
    output logic [WIDTH-1:0] MAR_q,
    output logic [WIDTH-1:0] IR_q,
    output logic [WIDTH-1:0] PC_q,
    output logic [WIDTH-1:0] R1_q
);

`ifdef DATAPATH_MUL_EN
    localparam int ZW = 2 * WIDTH;
`else
    localparam int ZW = WIDTH;
`endif

    localparam logic [4:0] OP_AND = 5'd0;
    localparam logic [4:0] OP_OR  = 5'd1;
    localparam logic [4:0] OP_ADD = 5'd2;
    localparam logic [4:0] OP_SUB = 5'd3;
    localparam logic [4:0] OP_SHR = 5'd4;
    localparam logic [4:0] OP_SHL = 5'd5;
    localparam logic [4:0] OP_NOT = 5'd6;
    localparam logic [4:0] OP_NEG = 5'd7;
`ifdef DATAPATH_MUL_EN
    localparam logic [4:0] OP_MUL = 5'd8;
`endif

    logic [WIDTH-1:0] r1, r2, r3, pc, ir, mar, mdr, y;
    logic [ZW-1:0]    z;
    logic [WIDTH-1:0] bus;
    logic [ZW-1:0]    alu_res;
    logic [4:0]       opcode;

    assign opcode = ir[WIDTH-1:WIDTH-5];

    // Bus mux: fixed priority, bus floats to zero when nobody drives it.
    always_comb begin
        bus = '0;
        if (MDRout)
            bus = mdr;
        else if (Zlowout)
            bus = z[WIDTH-1:0];
`ifdef DATAPATH_MUL_EN
        else if (Zhighout)
            bus = z[ZW-1:WIDTH];
`endif
        else if (PCout)
            bus = pc;
        else if (R1out)
            bus = r1;
        else if (R2out)
            bus = r2;
        else if (R3out)
            bus = r3;
    end

    // ALU: 32-bit results are zero-extended so the upper half of a wide Z
    // clears on every non-multiply operation.
    always_comb begin
        alu_res = '0;
        if (IncPC) begin
            alu_res = ZW'(bus + WIDTH'(1));
        end else begin
            case (opcode)
                OP_AND:  alu_res = ZW'(y & bus);
                OP_OR:   alu_res = ZW'(y | bus);
                OP_ADD:  alu_res = ZW'(y + bus);
                OP_SUB:  alu_res = ZW'(y - bus);
                OP_SHR:  alu_res = ZW'(y >> bus[4:0]);
                OP_SHL:  alu_res = ZW'(y << bus[4:0]);
                OP_NOT:  alu_res = ZW'(~bus);
                OP_NEG:  alu_res = ZW'(WIDTH'(0) - bus);
`ifdef DATAPATH_MUL_EN
                OP_MUL:  alu_res = ZW'(y) * ZW'(bus);
`endif
                default: alu_res = '0;
            endcase
        end
    end

    // Register file: reset wins over every in-enable; a register that drives
    // the bus while loading captures the pre-edge bus value.
    always_ff @(posedge clock) begin
        if (!clear) begin
            r1  <= '0;
            r2  <= '0;
            r3  <= '0;
            pc  <= '0;
            ir  <= '0;
            mar <= '0;
            mdr <= '0;
            y   <= '0;
            z   <= '0;
        end else begin
            if (R1in)   r1  <= bus;
            if (R2in)   r2  <= bus;
            if (R3in)   r3  <= bus;
            if (PCin)   pc  <= bus;
            if (IRin)   ir  <= bus;
            if (MARin)  mar <= bus;
            if (Yin)    y   <= bus;
            if (Zlowin) z   <= alu_res;
            if (MDRin)  mdr <= MD_read ? Mdatain : bus;
        end
    end

    assign BusMuxOut = bus;
    assign MAR_q     = mar;
    assign IR_q      = ir;
    assign PC_q      = pc;
    assign R1_q      = r1;

endmodule

// File: tb/tb_data_path.sv
module tb_data_path;

    localparam int W = 32;

    localparam int SEL_BUS = 0;
    localparam int SEL_MAR = 1;
    localparam int SEL_IR  = 2;
    localparam int SEL_PC  = 3;
    localparam int SEL_R1  = 4;

    typedef struct {
        string        name;
        int           sel;
        logic [W-1:0] exp;
    } sb_item_t;

    logic clock = 1'b0;
    logic clear;
    logic R1in, R2in, R3in, R1out, R2out, R3out;
    logic MDRin, MDRout, MD_read, MARin, PCin, PCout, IRin, Yin;
    logic Zlowin, Zlowout, IncPC;
`ifdef DATAPATH_MUL_EN
    logic Zhighout;
`endif
    logic [W-1:0] Mdatain;
    logic [W-1:0] BusMuxOut, MAR_q, IR_q, PC_q, R1_q;

    sb_item_t sb[$];
    int checks = 0;
    int passed = 0;

    data_path #(.WIDTH(W)) dut (
        .clock    (clock),
        .clear    (clear),
        .R1in     (R1in),
        .R2in     (R2in),
        .R3in     (R3in),
        .R1out    (R1out),
        .R2out    (R2out),
        .R3out    (R3out),
        .MDRin    (MDRin),
        .MDRout   (MDRout),
        .MD_read  (MD_read),
        .MARin    (MARin),
        .PCin     (PCin),
        .PCout    (PCout),
        .IRin     (IRin),
        .Yin      (Yin),
        .Zlowin   (Zlowin),
        .Zlowout  (Zlowout),
`ifdef DATAPATH_MUL_EN
        .Zhighout (Zhighout),
`endif
        .IncPC    (IncPC),
        .Mdatain  (Mdatain),
        .BusMuxOut(BusMuxOut),
        .MAR_q    (MAR_q),
        .IR_q     (IR_q),
        .PC_q     (PC_q),
        .R1_q     (R1_q)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, checks=%0d queued=%0d", checks, sb.size());
        $fatal(1, "timeout");
    end

    function automatic logic [W-1:0] observe(int sel);
        case (sel)
            SEL_MAR: return MAR_q;
            SEL_IR:  return IR_q;
            SEL_PC:  return PC_q;
            SEL_R1:  return R1_q;
            default: return BusMuxOut;
        endcase
    endfunction

    // Monitor: on each falling edge (inputs and registers stable) pop every
    // queued expectation and compare against the DUT.
    always @(negedge clock) begin
        while (sb.size() > 0) begin
            sb_item_t it;
            logic [W-1:0] act;
            it  = sb.pop_front();
            act = observe(it.sel);
            checks++;
            if (act === it.exp)
                passed++;
            else
                $display("FAIL %s: got 0x%08h expected 0x%08h", it.name, act, it.exp);
        end
    end

    task automatic expect_val(input string nm, input int sel, input logic [W-1:0] v);
        sb_item_t it;
        it.name = nm;
        it.sel  = sel;
        it.exp  = v;
        sb.push_back(it);
    endtask

    task automatic clr_ctl();
        R1in = 0; R2in = 0; R3in = 0; R1out = 0; R2out = 0; R3out = 0;
        MDRin = 0; MDRout = 0; MD_read = 0; MARin = 0; PCin = 0; PCout = 0;
        IRin = 0; Yin = 0; Zlowin = 0; Zlowout = 0; IncPC = 0;
`ifdef DATAPATH_MUL_EN
        Zhighout = 0;
`endif
    endtask

    // Apply the current enables across one rising edge, then drop them.
    task automatic tick();
        @(posedge clock);
        #1;
        clr_ctl();
    endtask

    task automatic load_mdr(input logic [W-1:0] v);
        Mdatain = v; MD_read = 1; MDRin = 1;
        tick();
    endtask

    initial begin
        clr_ctl();
        clear   = 0;
        Mdatain = '0;
        repeat (2) @(posedge clock);
        #1;
        clear = 1;

        // Reset: fill registers with ones, then reset mid-transfer.
        load_mdr(32'hFFFF_FFFF);
        MDRout = 1; R2in = 1; R1in = 1; PCin = 1; MARin = 1; IRin = 1;
        expect_val("fill_bus", SEL_BUS, 32'hFFFF_FFFF);
        tick();
        expect_val("fill_r1", SEL_R1, 32'hFFFF_FFFF);
        expect_val("fill_pc", SEL_PC, 32'hFFFF_FFFF);
        clear = 0; R2out = 1; R1in = 1; PCin = 1;
        expect_val("reset_bus_follows_enables", SEL_BUS, 32'hFFFF_FFFF);
        tick();
        clear = 1;
        expect_val("reset_r1", SEL_R1, 32'h0);
        expect_val("reset_pc", SEL_PC, 32'h0);
        expect_val("reset_mar", SEL_MAR, 32'h0);
        expect_val("reset_ir", SEL_IR, 32'h0);
        R2out = 1;
        expect_val("reset_r2_bus", SEL_BUS, 32'h0);
        tick();

        // MDR load from memory, then MDR -> R2.
        load_mdr(32'h0000_0003);
        MDRout = 1; R2in = 1;
        expect_val("mdr_bus", SEL_BUS, 32'h0000_0003);
        tick();

        // AND execute: R1 = R2 & R3 with IR opcode 0.
        load_mdr(32'h0000_000D);
        MDRout = 1; R3in = 1;
        tick();
        R2out = 1; Yin = 1;
        expect_val("and_r2_bus", SEL_BUS, 32'h0000_0003);
        tick();
        R3out = 1; Zlowin = 1;
        expect_val("and_r3_bus", SEL_BUS, 32'h0000_000D);
        tick();
        Zlowout = 1; R1in = 1;
        expect_val("and_z_bus", SEL_BUS, 32'h0000_0001);
        tick();
        expect_val("and_r1", SEL_R1, 32'h0000_0001);

        // Fetch with PC increment from PC=0x10.
        load_mdr(32'h0000_0010);
        MDRout = 1; PCin = 1;
        tick();
        expect_val("fetch_pc_init", SEL_PC, 32'h0000_0010);
        PCout = 1; MARin = 1; IncPC = 1; Zlowin = 1;
        expect_val("fetch_pc_bus", SEL_BUS, 32'h0000_0010);
        tick();
        expect_val("fetch_mar", SEL_MAR, 32'h0000_0010);
        Zlowout = 1; PCin = 1; MD_read = 1; MDRin = 1; Mdatain = 32'h1000_0000;
        expect_val("fetch_z_inc", SEL_BUS, 32'h0000_0011);
        tick();
        expect_val("fetch_pc_inc", SEL_PC, 32'h0000_0011);
        MDRout = 1; IRin = 1;
        expect_val("fetch_ir_bus", SEL_BUS, 32'h1000_0000);
        tick();
        expect_val("fetch_ir", SEL_IR, 32'h1000_0000);

        // ADD wraparound: Y=0xFFFFFFFF plus R2=2.
        load_mdr(32'hFFFF_FFFF);
        MDRout = 1; Yin = 1;
        tick();
        load_mdr(32'h0000_0002);
        MDRout = 1; R2in = 1;
        tick();
        R2out = 1; Zlowin = 1;
        expect_val("add_r2_bus", SEL_BUS, 32'h0000_0002);
        tick();
        Zlowout = 1; R1in = 1;
        expect_val("add_wrap_z", SEL_BUS, 32'h0000_0001);
        tick();
        expect_val("no_driver_bus", SEL_BUS, 32'h0);
        tick();

        // Bus priority: Z=0x55 via IncPC, MDR=0xAA.
        load_mdr(32'h0000_0054);
        MDRout = 1; IncPC = 1; Zlowin = 1;
        tick();
        load_mdr(32'h0000_00AA);
        MDRout = 1; Zlowout = 1; R3in = 1;
        expect_val("prio_mdr_over_z", SEL_BUS, 32'h0000_00AA);
        tick();
        R3out = 1;
        expect_val("prio_r3", SEL_BUS, 32'h0000_00AA);
        tick();
        Zlowout = 1; PCout = 1; R1out = 1;
        expect_val("prio_z_over_pc", SEL_BUS, 32'h0000_0055);
        tick();
        PCout = 1; R1out = 1; R2out = 1;
        expect_val("prio_pc_over_r1", SEL_BUS, 32'h0000_0011);
        tick();
        R1out = 1; R2out = 1; R3out = 1;
        expect_val("prio_r1_over_r2", SEL_BUS, 32'h0000_0001);
        tick();

        // Z drives and loads together: Z = Y + Z_old = 0xFFFFFFFF + 0x55.
        Zlowout = 1; Zlowin = 1;
        expect_val("zz_old", SEL_BUS, 32'h0000_0055);
        tick();
        Zlowout = 1;
        expect_val("zz_new", SEL_BUS, 32'h0000_0054);
        tick();

        // MD_read without MDRin leaves MDR alone.
        MD_read = 1; Mdatain = 32'hDEAD_BEEF;
        tick();
        MDRout = 1;
        expect_val("mdread_no_load", SEL_BUS, 32'h0000_00AA);
        tick();

        repeat (3) @(negedge clock);
        if (sb.size() != 0) begin
            checks++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/data_path.md
Name:
data_path

Overview:
- 32-bit single-bus processor datapath.
- Holds general registers R1–R3, PC, IR, MAR, MDR, Y and Z, plus a combinational ALU.
- All register-to-register transfers go over one shared bus, gated by per-register out-enables and in-enables.
- An external control unit (or bench FSM) steps it through fetch and execute micro-steps.

Parameters:
- WIDTH, 32, bus and register width. Only 32 is supported.

Ports:
- clock  in  1  rising-edge clock for all registers.
- clear  in  1  reset, synchronous, active-low.
- R1in, R2in, R3in  in  1 each  load the named register from the bus.
- R2out, R3out  in  1 each  drive the named register onto the bus.
- MDRin  in  1  load MDR from the MDR input mux.
- MDRout  in  1  drive MDR onto the bus.
- MD_read  in  1  MDR input mux select: 1 = Mdatain, 0 = bus.
- MARin  in  1  load MAR from the bus.
- PCin  in  1  load PC from the bus.
- PCout  in  1  drive PC onto the bus. Tie 0 if unused.
- R1out  in  1  drive R1 onto the bus. Tie 0 if unused.
- IRin  in  1  load IR from the bus.
- Yin  in  1  load Y from the bus.
- Zlowin  in  1  load Z from the ALU result.
- Zlowout  in  1  drive Z[31:0] onto the bus.
- IncPC  in  1  force the ALU to compute bus+1.
- Mdatain  in  32  memory read data.
- BusMuxOut  out  32  current bus value.
- MAR_q, IR_q, PC_q, R1_q  out  32 each  register observation outputs.

Behaviour:
- Registers:
  - Every register updates only on the rising edge of clock.
  - When clear=0 at an edge, R1–R3, PC, IR, MAR, MDR, Y and Z all become 0. Reset overrides every in-enable.
  - Otherwise a register loads when its in-enable is 1 and holds when it is 0.
- Bus mux:
  - Combinational.
  - Priority when several out-enables are high: MDRout > Zlowout > PCout > R1out > R2out > R3out.
  - No out-enable high: bus = 0.
- MDR:
  - Next value = MD_read ? Mdatain : bus, loaded when MDRin=1.
  - MD_read with MDRin=0 has no effect.
- ALU:
  - Combinational; operand A = Y, operand B = bus.
  - The operation comes from the opcode IR[31:27].
  - IncPC=1 overrides the opcode and gives result = bus + 1.
  - Opcode map:
    - 0 AND: A & B
    - 1 OR: A | B
    - 2 ADD: A + B, wraps mod 2^32
    - 3 SUB: A − B, wraps
    - 4 SHR: A >> B[4:0], logical
    - 5 SHL: A << B[4:0]
    - 6 NOT: ~B
    - 7 NEG: 0 − B
    - 8 MUL: see optional feature
    - all others: result 0
- Z:
  - Z loads the ALU result when Zlowin=1.
  - Zlowout places Z[31:0] on the bus.
- Timing:
  - A transfer source→dest completes in one cycle: out-enable and in-enable are high together across one rising edge.
  - The new value is visible on the *_q outputs after that edge.
- Simultaneous events:
  - A register may drive the bus and load in the same cycle; it captures the pre-edge bus value.
  - Zlowout with Zlowin loads Z with f(Y, Z_old).
- Mid-operation reset:
  - clear=0 during any step discards the step.
  - All state is 0 on the next edge; the combinational bus still reflects the enables.
- Observation outputs: MAR_q, IR_q, PC_q and R1_q reflect the register contents directly, with no extra latency.

Optional Feature:
DATAPATH_MUL_EN
- Defined:
  - Z is 64 bits (Zhigh:Zlow).
  - Opcode 8 gives the unsigned 64-bit product A*B, loaded into Z on Zlowin.
  - Adds input port Zhighout (1 bit), which drives Z[63:32] on the bus, priority just below Zlowout.
  - For non-MUL ops, Zhigh loads 0.
- Not defined:
  - Z is 32 bits and there is no Zhighout port.
  - Opcode 8 yields result 0.

Test Plan:
- Reset: load R2=0xFFFFFFFF, then drive clear=0 for one edge -> R1_q, PC_q, MAR_q, IR_q all 0. A subsequent R2out transfer shows bus=0.
- MDR load: Mdatain=0x00000003, MD_read=1, MDRin=1 for one edge; then MDRout=1, R2in=1 for one edge -> BusMuxOut=3 during that cycle, R2=3.
- AND execute:
  - Setup: R2=3, R3=0x0000000D, R1=0, IR=0x00000000.
  - Steps: R2out+Yin; R3out+Zlowin (BusMuxOut=0xD); Zlowout+R1in.
  - Required: R1_q=0x00000001.
- Fetch increment, starting from PC=0x10:
  - PCout+MARin+IncPC+Zlowin -> MAR_q=0x10, Z=0x11.
  - Zlowout+PCin+MD_read+MDRin with Mdatain=0x10000000 -> PC_q=0x11.
  - MDRout+IRin -> IR_q=0x10000000 (opcode 2 = ADD).
- Wrap and no driver:
  - With IR opcode ADD, Y=0xFFFFFFFF, R2=2: R2out+Zlowin -> Z=0x00000001.
  - No out-enable asserted -> BusMuxOut=0.
- Bus priority: MDR=0xAA and Z=0x55; assert MDRout and Zlowout together with R3in -> R3=0xAA.
